// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared types and default sizes for the synth voice path
package synth_pkg;

  localparam int DEF_NUM_UNITS  = 4;
  localparam int DEF_FREQ_WIDTH = 16;
  localparam int DEF_NOTE_WIDTH = 7;
  localparam int DEF_AGE_WIDTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_SEARCH,
    ST_GAP1,
    ST_GAP2
  } alloc_state_t;

endpackage

// File: rtl/note_freq_rom.sv
// rtl/note_freq_rom.sv - note number to integer Hz lookup, one-cycle registered read
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   note     : note number (0..127 for the default width)
//   freq     : round(440 * 2^((note-69)/12)) saturated to FREQ_WIDTH, valid one cycle after note
module note_freq_rom #(
  parameter int NOTE_WIDTH = 7,
  parameter int FREQ_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NOTE_WIDTH-1:0] note,
  output logic [FREQ_WIDTH-1:0] freq
);

  localparam int FRAC = 20;
  localparam int PW   = 48;

  // Notes 0..11 in Q.20; every higher octave is an exact doubling, so the
  // table entry is shifted by the octave number and rounded once at the end.
  function automatic logic [23:0] base_q20(input int semi);
    case (semi)
      0:       base_q20 = 24'd8572947;
      1:       base_q20 = 24'd9082720;
      2:       base_q20 = 24'd9622807;
      3:       base_q20 = 24'd10195009;
      4:       base_q20 = 24'd10801236;
      5:       base_q20 = 24'd11443511;
      6:       base_q20 = 24'd12123977;
      7:       base_q20 = 24'd12844906;
      8:       base_q20 = 24'd13608704;
      9:       base_q20 = 24'd14417920;
      10:      base_q20 = 24'd15275254;
      11:      base_q20 = 24'd16183568;
      default: base_q20 = 24'd0;
    endcase
  endfunction

  logic [NOTE_WIDTH-1:0] octave;
  logic [NOTE_WIDTH-1:0] semi;
  logic [PW-1:0]         scaled;
  logic [PW-1:0]         rounded;
  logic [FREQ_WIDTH-1:0] freq_sat;

  always_comb begin
    octave   = note / NOTE_WIDTH'(12);
    semi     = note % NOTE_WIDTH'(12);
    scaled   = PW'(base_q20(int'(semi))) << octave;
    rounded  = (scaled + (PW'(1) << (FRAC - 1))) >> FRAC;
    freq_sat = rounded[FREQ_WIDTH-1:0];
    if (rounded > PW'({FREQ_WIDTH{1'b1}})) begin
      freq_sat = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq <= '0;
    end else begin
      freq <= freq_sat;
    end
  end

endmodule

// File: rtl/synth_voice_alloc.sv
// rtl/synth_voice_alloc.sv - polyphonic note-event to synthesis-unit allocator
// Ports:
//   ctl_clk, ctl_rst : only clock; asynchronous active-high reset
//   ev_valid/ev_ready, ev_note_on, ev_note : note event handshake (on/off + note number)
//   ch_in_use    : per-unit envelope-busy feedback from synth, looked at only in SEARCH
//   vco_freq_out : packed per-unit frequency, unit i at [FREQ_WIDTH*(i+1)-1 : FREQ_WIDTH*i]
//   trigger      : per-unit gate to synth
//   stolen       : one-cycle pulse when a held unit is taken for a new note
module synth_voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_UNITS  = DEF_NUM_UNITS,
  parameter int FREQ_WIDTH = DEF_FREQ_WIDTH,
  parameter int NOTE_WIDTH = DEF_NOTE_WIDTH,
  parameter int AGE_WIDTH  = DEF_AGE_WIDTH
) (
  input  logic                            ctl_clk,
  input  logic                            ctl_rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_note_on,
  input  logic [NOTE_WIDTH-1:0]           ev_note,
  input  logic [NUM_UNITS-1:0]            ch_in_use,
  output logic [FREQ_WIDTH*NUM_UNITS-1:0] vco_freq_out,
  output logic [NUM_UNITS-1:0]            trigger,
  output logic                            stolen
);

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  alloc_state_t          state, state_nxt;
  logic [NOTE_WIDTH-1:0] cur_note;
  logic                  cur_on;
  logic [FREQ_WIDTH-1:0] rom_freq;
  logic [NOTE_WIDTH-1:0] unit_note [NUM_UNITS];
  logic [AGE_WIDTH-1:0]  unit_age  [NUM_UNITS];
  logic [UW-1:0]         gap_unit;

  logic                  match_hit, free_hit, rel_hit;
  logic [UW-1:0]         match_idx, free_idx, rel_idx, old_idx;
  logic [AGE_WIDTH-1:0]  rel_age, old_age;

  logic                  act_direct, act_gap, act_off, act_steal;
  logic [UW-1:0]         act_unit;

  note_freq_rom #(
    .NOTE_WIDTH (NOTE_WIDTH),
    .FREQ_WIDTH (FREQ_WIDTH)
  ) u_rom (
    .clk  (ctl_clk),
    .rst  (ctl_rst),
    .note (cur_note),
    .freq (rom_freq)
  );

  // Candidate units. Strict '>' keeps age ties on the lowest index. The
  // oldest-overall pick is only used when every unit is held.
  always_comb begin
    match_hit = 1'b0;
    free_hit  = 1'b0;
    rel_hit   = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    rel_idx   = '0;
    rel_age   = '0;
    old_idx   = '0;
    old_age   = unit_age[0];
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (trigger[i]) begin
        if (!match_hit && unit_note[i] == cur_note) begin
          match_hit = 1'b1;
          match_idx = UW'(i);
        end
      end else begin
        if (!free_hit && !ch_in_use[i]) begin
          free_hit = 1'b1;
          free_idx = UW'(i);
        end
        if (!rel_hit || unit_age[i] > rel_age) begin
          rel_hit = 1'b1;
          rel_idx = UW'(i);
          rel_age = unit_age[i];
        end
      end
      if (unit_age[i] > old_age) begin
        old_idx = UW'(i);
        old_age = unit_age[i];
      end
    end
  end

  always_ff @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    act_direct = 1'b0;
    act_gap    = 1'b0;
    act_off    = 1'b0;
    act_steal  = 1'b0;
    act_unit   = '0;
    case (state)
      ST_IDLE:   if (ev_valid) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_SEARCH;
      ST_SEARCH: begin
        state_nxt = ST_IDLE;
        if (!cur_on) begin
          act_off  = match_hit;
          act_unit = match_idx;
        end else if (match_hit) begin
          act_gap   = 1'b1;
          act_unit  = match_idx;
          state_nxt = ST_GAP1;
        end else if (free_hit) begin
          act_direct = 1'b1;
          act_unit   = free_idx;
        end else if (rel_hit) begin
          act_direct = 1'b1;
          act_unit   = rel_idx;
        end else begin
          act_gap   = 1'b1;
          act_steal = 1'b1;
          act_unit  = old_idx;
          state_nxt = ST_GAP1;
        end
      end
      ST_GAP1:   state_nxt = ST_GAP2;
      ST_GAP2:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign ev_ready = (state == ST_IDLE);

  always_ff @(posedge ctl_clk or posedge ctl_rst) begin
    if (ctl_rst) begin
      cur_note     <= '0;
      cur_on       <= 1'b0;
      gap_unit     <= '0;
      stolen       <= 1'b0;
      trigger      <= '0;
      vco_freq_out <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        unit_note[i] <= '0;
        unit_age[i]  <= '0;
      end
    end else begin
      stolen <= act_steal;
      if (state == ST_IDLE && ev_valid) begin
        cur_note <= ev_note;
        cur_on   <= ev_note_on;
      end
      if (act_gap) begin
        gap_unit <= act_unit;
      end
      // Ages move at decision time for every note-on, including retriggers.
      if (act_direct || act_gap) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          if (UW'(i) == act_unit) begin
            unit_age[i] <= '0;
          end else if (unit_age[i] != AGE_MAX) begin
            unit_age[i] <= unit_age[i] + 1'b1;
          end
        end
      end
      if (act_off || act_gap) begin
        trigger[act_unit] <= 1'b0;
      end
      if (act_direct) begin
        vco_freq_out[act_unit*FREQ_WIDTH +: FREQ_WIDTH] <= rom_freq;
        unit_note[act_unit]                             <= cur_note;
        trigger[act_unit]                               <= 1'b1;
      end
      // The gate was held low through GAP1/GAP2 so the envelope sees a release.
      if (state == ST_GAP2) begin
        vco_freq_out[gap_unit*FREQ_WIDTH +: FREQ_WIDTH] <= rom_freq;
        unit_note[gap_unit]                             <= cur_note;
        trigger[gap_unit]                               <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_synth_voice_alloc.sv
// tb/tb_synth_voice_alloc.sv - randomized model-checked bench for synth_voice_alloc
module tb_synth_voice_alloc;

  logic        clk = 1'b0;
  logic        ctl_rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_note_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [3:0]  ch_in_use = '0;
  logic [63:0] vco_freq_out;
  logic [3:0]  trigger;
  logic        stolen;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference state: a unit's age is the number of allocations since it was
  // last chosen, saturating at 255; kept as allocation timestamps.
  int now_cnt;
  int stamp  [4];
  bit m_trig [4];
  int m_note [4];
  int m_freq [4];

  synth_voice_alloc dut (
    .ctl_clk      (clk),
    .ctl_rst      (ctl_rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_note      (ev_note),
    .ch_in_use    (ch_in_use),
    .vco_freq_out (vco_freq_out),
    .trigger      (trigger),
    .stolen       (stolen)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_freq(input int n);
    real f;
    int  r;
    f = 440.0 * $pow(2.0, (n - 69) / 12.0);
    r = $rtoi(f + 0.5);
    return (r > 65535) ? 65535 : r;
  endfunction

  function automatic int age_of(input int i);
    int a;
    a = now_cnt - stamp[i];
    return (a > 255) ? 255 : a;
  endfunction

  function automatic logic [63:0] exp_freq_bus();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(m_freq[i]);
    return v;
  endfunction

  function automatic logic [63:0] exp_trig_bus();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i] = m_trig[i];
    return v;
  endfunction

  task automatic model_reset();
    now_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      stamp[i] = 0; m_trig[i] = 0; m_note[i] = 0; m_freq[i] = 0;
    end
  endtask

  task automatic do_reset();
    ev_valid = 1'b0;
    ctl_rst  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ctl_rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready();
    int tmo;
    tmo = 0;
    while (!ev_ready && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    check_val("ready_idle", ev_ready, 1);
  endtask

  // kind: 0 direct, 1 through gap, 2 note-off hit, 3 dropped
  task automatic do_event(input bit on, input int note, input logic [3:0] cin);
    int kind, u, mu, best;
    bit exp_st;
    kind = 3; u = -1; mu = -1; exp_st = 0;
    for (int i = 0; i < 4; i++) if (m_trig[i] && m_note[i] == note && mu < 0) mu = i;
    if (!on) begin
      if (mu >= 0) begin kind = 2; u = mu; end
    end else if (mu >= 0) begin
      kind = 1; u = mu;
    end else begin
      for (int i = 0; i < 4; i++) if (!m_trig[i] && !cin[i] && u < 0) u = i;
      if (u >= 0) kind = 0;
      else begin
        best = -1;
        for (int i = 0; i < 4; i++)
          if (!m_trig[i] && (best < 0 || age_of(i) > age_of(best))) best = i;
        if (best >= 0) begin
          kind = 0; u = best;
        end else begin
          best = 0;
          for (int i = 1; i < 4; i++) if (age_of(i) > age_of(best)) best = i;
          kind = 1; u = best; exp_st = 1;
        end
      end
    end
    if (on) begin
      now_cnt++;
      stamp[u] = now_cnt;
    end

    wait_ready();
    ev_valid = 1'b1; ev_note_on = on; ev_note = 7'(note); ch_in_use = cin;
    @(negedge clk);
    ev_valid = 1'b0;
    check_val("busy_c1", ev_ready, 0);
    @(negedge clk);
    check_val("busy_c2", ev_ready, 0);
    @(negedge clk);
    if (kind == 1) begin
      m_trig[u] = 0;
      check_val("gap_trig_c3", 64'(trigger), exp_trig_bus());
      check_val("gap_freq_c3", vco_freq_out, exp_freq_bus());
      check_val("stolen_c3", stolen, exp_st);
      check_val("gap_busy_c3", ev_ready, 0);
      @(negedge clk);
      check_val("gap_trig_c4", 64'(trigger), exp_trig_bus());
      check_val("stolen_c4", stolen, 0);
      check_val("gap_busy_c4", ev_ready, 0);
      @(negedge clk);
      m_trig[u] = 1; m_note[u] = note; m_freq[u] = ref_freq(note);
    end else begin
      if (kind == 0) begin
        m_trig[u] = 1; m_note[u] = note; m_freq[u] = ref_freq(note);
      end
      if (kind == 2) m_trig[u] = 0;
      check_val("stolen_quiet", stolen, 0);
    end
    check_val("trig_bus", 64'(trigger), exp_trig_bus());
    check_val("freq_bus", vco_freq_out, exp_freq_bus());
    check_val("ready_back", ev_ready, 1);
  endtask

  int pool [8] = '{0, 57, 60, 62, 64, 69, 81, 127};

  initial begin
    int note;
    bit on;
    model_reset();
    do_reset();
    check_val("rst_trig", 64'(trigger), 0);
    check_val("rst_freq", vco_freq_out, 0);
    check_val("rst_stolen", stolen, 0);
    check_val("rst_ready", ev_ready, 1);

    do_event(1, 69, 4'h0);
    check_val("u0_440", 64'(vco_freq_out[15:0]), 440);
    do_event(1, 60, 4'h0);
    check_val("u1_262", 64'(vco_freq_out[31:16]), 262);
    check_val("trig_0011", 64'(trigger), 64'h3);
    do_event(0, 69, 4'h0);
    check_val("off_keeps_440", 64'(vco_freq_out[15:0]), 440);
    do_event(0, 50, 4'h0);

    do_reset();
    do_event(1, 60, 4'h0);
    do_event(1, 62, 4'h0);
    do_event(1, 64, 4'h0);
    do_event(1, 65, 4'h0);
    do_event(1, 67, 4'hF);
    check_val("steal_u0_392", 64'(vco_freq_out[15:0]), 392);
    do_event(0, 64, 4'h0);
    do_event(0, 65, 4'h0);
    do_event(1, 70, 4'b0100);
    check_val("pick_u3", 64'(trigger[3]), 1);
    do_event(0, 62, 4'b0100);
    do_event(1, 81, 4'b0100);
    do_event(1, 81, 4'b0100);
    check_val("retrig_880", 64'(vco_freq_out[31:16]), 880);

    for (int k = 0; k < 160; k++) begin
      if ($urandom_range(0, 3) == 0) note = $urandom_range(0, 127);
      else note = pool[$urandom_range(0, 7)];
      on = ($urandom_range(0, 9) < 6);
      do_event(on, note, 4'($urandom));
    end

    do_reset();
    do_event(1, 69, 4'h0);
    wait_ready();
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd69; ch_in_use = 4'h0;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("gap1_low", 64'(trigger), 0);
    ctl_rst = 1'b1;
    #1;
    check_val("midrst_trig", 64'(trigger), 0);
    check_val("midrst_freq", vco_freq_out, 0);
    check_val("midrst_ready", ev_ready, 1);
    @(negedge clk);
    ctl_rst = 1'b0;
    model_reset();
    do_event(1, 72, 4'h0);
    check_val("after_rst_u0", 64'(trigger), 64'h1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
